// File: rtl/cu_test_sequencer.sv
// ---------------------------------------------------------------------------
// cu_test_sequencer
//   Bring-up sequencer for the SPARC datapath/CU pair. It copies a program
//   image from a source ROM into datapath RAM and holds the DUT in reset for
//   a fixed interval. It then issues a programmable number of clock-enable
//   steps and records a multi-channel trace into a circular buffer. The
//   buffer can be popped once the sequence has finished.
//
// Ports
//   Clk, Reset      : rising-edge clock, synchronous active-low reset
//   start           : one-cycle pulse; accepted only in IDLE or DONE
//   run_cycles      : number of DUT steps, latched when start is accepted
//   src_addr/data   : program ROM read port (data combinational from addr)
//   mem_we/addr/wdata : datapath RAM write port, active during LOAD
//   dut_reset_n     : active-low reset to the DUT
//   dut_step        : DUT clock enable, one pulse per step
//   trc_in          : concatenated trace channels, channel 0 in the LSBs
//   trc_rd_en       : pop the oldest trace entry (honoured only when idle)
//   trc_rd_data/valid : popped entry, valid the cycle after trc_rd_en
//   trc_count       : number of entries held
//   trc_ovf         : sticky flag; an entry was overwritten
//   busy, done      : sequence status
// ---------------------------------------------------------------------------

// Storage for one trace channel. There is one instance per channel so that
// each channel maps onto its own narrow RAM.
module cu_trace_lane #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              Clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
endmodule

module cu_test_sequencer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 7,
    parameter int LOAD_WORDS  = 128,
    parameter int RST_HOLD    = 4,
    parameter int TRACE_CH    = 3,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         start,
    input  logic [15:0]                  run_cycles,
    output logic [ADDR_W-1:0]            src_addr,
    input  logic [DATA_W-1:0]            src_data,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic                         dut_reset_n,
    output logic                         dut_step,
    input  logic [TRACE_CH*DATA_W-1:0]   trc_in,
    input  logic                         trc_rd_en,
    output logic [TRACE_CH*DATA_W-1:0]   trc_rd_data,
    output logic                         trc_rd_valid,
    output logic [$clog2(TRACE_DEPTH):0] trc_count,
    output logic                         trc_ovf,
    output logic                         busy,
    output logic                         done
);
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // One counter is shared by LOAD, HOLD and RUN. LOAD_WORDS and RST_HOLD
    // must therefore fit in 16 bits, which is the width of run_cycles.
    localparam int SEQ_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [SEQ_W-1:0]  seq_cnt;
    logic [15:0]       run_lat;
    logic              start_acc;
    logic              cap_vld;   // the step issued last cycle is now visible on trc_in
    logic              rd_ok;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [TRACE_CH-1:0][DATA_W-1:0] trc_in_ch;
    logic [TRACE_CH-1:0][DATA_W-1:0] lane_rd;

    assign start_acc = start && (state == S_IDLE || state == S_DONE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (seq_cnt == SEQ_W'(LOAD_WORDS - 1)) state_nxt = S_HOLD;
            S_HOLD:  if (seq_cnt == SEQ_W'(RST_HOLD - 1))   state_nxt = S_RUN;
            S_RUN: begin
                // A zero-length run skips DRAIN because nothing was captured.
                if (run_lat == 16'd0)                  state_nxt = S_DONE;
                else if (seq_cnt == run_lat - 16'd1)   state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        src_addr    = '0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        dut_reset_n = 1'b0;
        dut_step    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_LOAD: begin
                // ROM read and RAM write happen in the same cycle.
                src_addr  = seq_cnt[ADDR_W-1:0];
                mem_we    = 1'b1;
                mem_addr  = seq_cnt[ADDR_W-1:0];
                mem_wdata = src_data;
                busy      = 1'b1;
            end
            S_HOLD: busy = 1'b1;
            S_RUN: begin
                dut_reset_n = 1'b1;
                dut_step    = (run_lat != 16'd0);
                busy        = 1'b1;
            end
            S_DRAIN: begin
                dut_reset_n = 1'b1;
                busy        = 1'b1;
            end
            S_DONE: begin
                dut_reset_n = 1'b1;
                done        = 1'b1;
            end
            default: ;
        endcase
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge Clk) begin
        if (!Reset)                  seq_cnt <= '0;
        else if (state != state_nxt) seq_cnt <= '0;
        else if (busy)               seq_cnt <= seq_cnt + SEQ_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (!Reset)         run_lat <= '0;
        else if (start_acc) run_lat <= run_cycles;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) cap_vld <= 1'b0;
        else        cap_vld <= dut_step;
    end

    // ---------------- trace buffer ----------------
    assign trc_in_ch = trc_in;

    for (genvar c = 0; c < TRACE_CH; c++) begin : g_lane
        cu_trace_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (TRACE_DEPTH),
            .PTR_W  (PTR_W)
        ) u_lane (
            .Clk     (Clk),
            .wr_en   (cap_vld),
            .wr_ptr  (wr_ptr),
            .wr_data (trc_in_ch[c]),
            .rd_ptr  (rd_ptr),
            .rd_data (lane_rd[c])
        );
    end

    // Captures only happen while busy and reads only while idle, so the two
    // never compete for the pointers.
    assign rd_ok = trc_rd_en && !busy && (trc_count != '0);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            trc_count    <= '0;
            trc_ovf      <= 1'b0;
            trc_rd_valid <= 1'b0;
            trc_rd_data  <= '0;
        end else begin
            trc_rd_valid <= 1'b0;
            if (start_acc) begin
                // A new sequence wins over a concurrent read.
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                trc_count <= '0;
                trc_ovf   <= 1'b0;
            end else if (cap_vld) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (trc_count == CNT_W'(TRACE_DEPTH)) begin
                    // Full: the oldest entry is overwritten, so skip past it.
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                    trc_ovf <= 1'b1;
                end else begin
                    trc_count <= trc_count + CNT_W'(1);
                end
            end else if (rd_ok) begin
                trc_rd_data  <= lane_rd;
                trc_rd_valid <= 1'b1;
                rd_ptr       <= rd_ptr + PTR_W'(1);
                trc_count    <= trc_count - CNT_W'(1);
            end
        end
    end
endmodule
